fact_bcd_converter: RTL

- Downstream stage of the factorial unit: takes its 16-bit binary result and converts it to packed BCD for display or readout.
- Sequential double-dabble converter, one shift per clock, with a start/done handshake matching the factorial unit's.
- Also reports the count of significant decimal digits so a display driver can blank leading zeros.

---
 rtl/fact_bcd_converter.sv | 85 ++++++++
 1 files changed

// File: rtl/fact_bcd_converter.sv
// Sequential double-dabble converter: turns the factorial unit's binary result
// into packed BCD, one shift per clock, and counts significant decimal digits.
module fact_bcd_converter #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [2:0]            ndigits
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       nd_next;

  // Add-3 adjust on every BCD nibble, then the shift; nd_next looks at the
  // post-shift BCD field so it is valid on the final shift edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sr_adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[BIN_W+4*i +: 4] >= 4'd5)
        sr_adj[BIN_W+4*i +: 4] = sr[BIN_W+4*i +: 4] + 4'd3;
    end
    sr_next = {sr_adj[SR_W-2:0], 1'b0};

    nd_next = 3'd1;
    for (int i = 1; i < DIGITS; i++) begin
      if (sr_next[BIN_W+4*i +: 4] != 4'd0)
        nd_next = 3'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state   <= S_IDLE;
      sr      <= '0;
      cnt     <= '0;
      bcd     <= '0;
      ndigits <= 3'd1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sr    <= {{(4*DIGITS){1'b0}}, bin};
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state   <= S_DONE;
            bcd     <= sr_next[SR_W-1 -: 4*DIGITS];
            ndigits <= nd_next;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
